// File: rtl/gaussian_smooth_if.sv
// ---------------------------------------------------------------------------
// gaussian_smooth_if
//   Pixel-stream bundle between a pixel source and the Gaussian smoothing
//   stage.
//   enb       source -> smoother : input pixel valid
//   In_Pixel  source -> smoother : unsigned 8-bit pixel, raster order
//   ready     smoother -> source : a pixel can be accepted this cycle
//   Smoothed  smoother -> source : smoothed 8-bit pixel, raster order
//   outValid  smoother -> source : Smoothed is valid this cycle
//   complete  smoother -> source : one-cycle end-of-frame pulse
//   Modports: master = pixel source / result consumer, slave = smoother.
// ---------------------------------------------------------------------------
interface gaussian_smooth_if;
  logic       enb;
  logic [7:0] In_Pixel;
  logic       ready;
  logic [7:0] Smoothed;
  logic       outValid;
  logic       complete;

  modport master (
    output enb,
    output In_Pixel,
    input  ready,
    input  Smoothed,
    input  outValid,
    input  complete
  );

  modport slave (
    input  enb,
    input  In_Pixel,
    output ready,
    output Smoothed,
    output outValid,
    output complete
  );
endinterface

// File: rtl/gaussian_smooth.sv
// ---------------------------------------------------------------------------
// gaussian_smooth
//   Streaming 3x3 Gaussian smoothing (weights 1 2 1 / 2 4 2 / 1 2 1, /16)
//   over a WIDTH x HEIGHT frame delivered in raster order. Two line buffers
//   hold the previous two rows; a 3x3 window is formed from two registered
//   columns plus the column being read at the current accept. Border outputs
//   are forced to 0. After the last input pixel the block drains the
//   remaining (all border) outputs, pulses complete, and returns to idle.
//
//   Parameters : WIDTH, HEIGHT  frame size in pixels (each >= 3)
//   Ports      : clk    rising-edge clock
//                reset  asynchronous, active-low
//                bus    gaussian_smooth_if.slave (enb/In_Pixel/ready in,
//                       Smoothed/outValid/complete out)
// ---------------------------------------------------------------------------
module gaussian_smooth #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32
) (
  input  logic               clk,
  input  logic               reset,
  gaussian_smooth_if.slave   bus
);

  localparam int DATA_W = 8;
  localparam int SUM_W  = 12;
  localparam int CW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Weighted 3x3 sum; 16 * 255 = 4080 fits in 12 bits unsigned.
  function automatic logic [SUM_W-1:0] kernel_sum(
    input logic [DATA_W-1:0] t0, input logic [DATA_W-1:0] t1, input logic [DATA_W-1:0] t2,
    input logic [DATA_W-1:0] m0, input logic [DATA_W-1:0] m1, input logic [DATA_W-1:0] m2,
    input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1, input logic [DATA_W-1:0] b2
  );
    logic [SUM_W-1:0] s;
    s = SUM_W'(t0) + (SUM_W'(t1) << 1) + SUM_W'(t2)
      + (SUM_W'(m0) << 1) + (SUM_W'(m1) << 2) + (SUM_W'(m2) << 1)
      + SUM_W'(b0) + (SUM_W'(b1) << 1) + SUM_W'(b2);
    return s;
  endfunction

  // Divide by 16 with truncation (floor).
  function automatic logic [DATA_W-1:0] scale16(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:4];
  endfunction

  state_t            state;
  logic              ready_q;
  logic              complete_q;
  logic              vld_p1;
  logic [DATA_W-1:0] smoothed_p1;

  // Input position (row/col of the next pixel to accept) and output position.
  logic [CW-1:0]     icol;
  logic [RW-1:0]     irow;
  logic [CW-1:0]     ocol;
  logic [RW-1:0]     orow;

  logic [DATA_W-1:0] lb_r1 [WIDTH];   // row above the current input row
  logic [DATA_W-1:0] lb_r2 [WIDTH];   // two rows above
  logic [DATA_W-1:0] win_p0 [3][2];   // [row top..bottom][older col, newer col]

  logic [DATA_W-1:0] col_top;
  logic [DATA_W-1:0] col_mid;
  logic [SUM_W-1:0]  sum_p0;
  logic              out_en;
  logic              in_last;
  logic              out_last;
  logic              out_border;

  // ---- stage p0: window formation and kernel sum (combinational) ----
  assign col_top = lb_r2[icol];
  assign col_mid = lb_r1[icol];

  assign sum_p0 = kernel_sum(win_p0[0][0], win_p0[0][1], col_top,
                             win_p0[1][0], win_p0[1][1], col_mid,
                             win_p0[2][0], win_p0[2][1], bus.In_Pixel);

  // Input index k >= WIDTH+1 yields output k-(WIDTH+1): true once past row 0
  // and past column 0 of row 1.
  assign out_en     = (irow != '0) && !((irow == RW'(1)) && (icol == '0));
  assign in_last    = (irow == RW'(HEIGHT-1)) && (icol == CW'(WIDTH-1));
  assign out_last   = (orow == RW'(HEIGHT-1)) && (ocol == CW'(WIDTH-1));
  assign out_border = (orow == '0) || (orow == RW'(HEIGHT-1)) ||
                      (ocol == '0) || (ocol == CW'(WIDTH-1));

  // Data storage carries no reset: stale contents only ever land on
  // positions that the border rule forces to 0.
  always_ff @(posedge clk) begin
    if (bus.enb && ready_q) begin
      lb_r2[icol]  <= lb_r1[icol];
      lb_r1[icol]  <= bus.In_Pixel;
      win_p0[0][0] <= win_p0[0][1];
      win_p0[1][0] <= win_p0[1][1];
      win_p0[2][0] <= win_p0[2][1];
      win_p0[0][1] <= col_top;
      win_p0[1][1] <= col_mid;
      win_p0[2][1] <= bus.In_Pixel;
    end
  end

  // ---- stage p1: registered output and frame control ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      complete_q  <= 1'b0;
      vld_p1      <= 1'b0;
      smoothed_p1 <= '0;
      icol        <= '0;
      irow        <= '0;
      ocol        <= '0;
      orow        <= '0;
    end else begin
      vld_p1     <= 1'b0;
      complete_q <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (bus.enb) begin
            if (out_en) begin
              vld_p1      <= 1'b1;
              smoothed_p1 <= out_border ? '0 : scale16(sum_p0);
              if (ocol == CW'(WIDTH-1)) begin
                ocol <= '0;
                orow <= orow + RW'(1);
              end else begin
                ocol <= ocol + CW'(1);
              end
            end
            if (in_last) begin
              state   <= FLUSH;
              ready_q <= 1'b0;
              icol    <= '0;
              irow    <= '0;
            end else begin
              state <= RUN;
              if (icol == CW'(WIDTH-1)) begin
                icol <= '0;
                irow <= irow + RW'(1);
              end else begin
                icol <= icol + CW'(1);
              end
            end
          end
        end
        FLUSH: begin
          // Remaining outputs lie on the right column / bottom row: all 0.
          vld_p1      <= 1'b1;
          smoothed_p1 <= '0;
          if (out_last) begin
            state      <= DONE;
            complete_q <= 1'b1;
            ocol       <= '0;
            orow       <= '0;
          end else if (ocol == CW'(WIDTH-1)) begin
            ocol <= '0;
            orow <= orow + RW'(1);
          end else begin
            ocol <= ocol + CW'(1);
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.outValid = vld_p1;
  assign bus.Smoothed = smoothed_p1;
  assign bus.complete = complete_q;

endmodule
